// File: rtl/obstacle_generator.sv
// rtl/obstacle_generator.sv - 10-slot obstacle field: spawn, scroll, free, score and speed ramp
//
// Ports:
//   clk              in   frame clock (60 Hz), rising edge
//   rst_n            in   asynchronous active-low reset
//   gamemode         in   00 clear, 01 run, 10 pause, 11 crashed
//   obstacle_x_left  out  per-slot left x  (10 slots x 10 bits)
//   obstacle_x_right out  per-slot right x (10 slots x 10 bits)
//   obstacle_y_up    out  per-slot top y   (10 slots x 9 bits)
//   obstacle_y_down  out  per-slot bottom y (10 slots x 9 bits)
//   score            out  obstacles passed by the player, saturating
//   speed            out  current scroll speed in pixels/frame
module obstacle_generator #(
  parameter int          NUM_OBS       = 10,
  parameter int          SCREEN_W      = 640,
  parameter int          OBS_WIDTH     = 40,
  parameter int          UPPER_BOUND   = 20,
  parameter int          MIN_H         = 40,
  parameter int          H_STEP        = 8,
  parameter int          PLAYER_X_LEFT = 160,
  parameter int          SPAWN_MIN     = 45,
  parameter int          INIT_SPEED    = 4,
  parameter int          MAX_SPEED     = 8,
  parameter int          LEVEL_FRAMES  = 600,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   gamemode,
  output logic [NUM_OBS-1:0][9:0]      obstacle_x_left,
  output logic [NUM_OBS-1:0][9:0]      obstacle_x_right,
  output logic [NUM_OBS-1:0][8:0]      obstacle_y_up,
  output logic [NUM_OBS-1:0][8:0]      obstacle_y_down,
  output logic [15:0]                  score,
  output logic [3:0]                   speed
);

  typedef enum logic [1:0] {
    GM_CLEAR = 2'b00,
    GM_RUN   = 2'b01,
    GM_PAUSE = 2'b10,
    GM_CRASH = 2'b11
  } gamemode_e;

  localparam int          PASS_W      = $clog2(NUM_OBS + 1);
  localparam logic [9:0]  SPAWN_XL    = 10'(SCREEN_W);
  localparam logic [9:0]  SPAWN_XR    = 10'(SCREEN_W + OBS_WIDTH);
  localparam logic [9:0]  PLAYER_X    = 10'(PLAYER_X_LEFT);
  localparam logic [8:0]  UPPER_C     = 9'(UPPER_BOUND);
  localparam logic [8:0]  MIN_H_C     = 9'(MIN_H);
  localparam logic [8:0]  H_STEP_C    = 9'(H_STEP);
  localparam logic [7:0]  SPAWN_MIN_C = 8'(SPAWN_MIN);
  localparam logic [3:0]  INIT_SPD_C  = 4'(INIT_SPEED);
  localparam logic [3:0]  MAX_SPD_C   = 4'(MAX_SPEED);
  localparam logic [15:0] LEVEL_LAST  = 16'(LEVEL_FRAMES - 1);

  logic [NUM_OBS-1:0][9:0] x_left_q,  x_left_d;
  logic [NUM_OBS-1:0][9:0] x_right_q, x_right_d;
  logic [NUM_OBS-1:0][8:0] y_up_q,    y_up_d;
  logic [NUM_OBS-1:0][8:0] y_down_q,  y_down_d;
  logic [15:0]             score_q,     score_d;
  logic [3:0]              speed_q,     speed_d;
  logic [7:0]              spawn_cnt_q, spawn_cnt_d;
  logic [15:0]             level_cnt_q, level_cnt_d;
  logic [15:0]             lfsr_q,      lfsr_d;

  logic [NUM_OBS-1:0]      slot_active;
  logic [NUM_OBS-1:0]      spawn_sel;
  logic                    free_found;
  logic [PASS_W-1:0]       pass_cnt;
  logic [16:0]             score_sum;
  logic [9:0]              speed_ext;
  logic [8:0]              spawn_y_up;
  logic [8:0]              spawn_y_down;

  assign speed_ext    = {6'd0, speed_q};
  assign spawn_y_up   = UPPER_C + {1'b0, lfsr_q[7:0]};
  assign spawn_y_down = spawn_y_up + MIN_H_C + ({5'd0, lfsr_q[13:10]} * H_STEP_C);

  // An all-zero slot is free; x_right 0 can never register as a hit.
  always_comb begin
    slot_active = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      slot_active[i] = |{x_left_q[i], x_right_q[i], y_up_q[i], y_down_q[i]};
    end
  end

  // Lowest-index free slot, judged on the pre-scroll state so a slot freed
  // this frame only becomes a spawn target on the next frame.
  always_comb begin
    spawn_sel  = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!slot_active[i] && !free_found) begin
        spawn_sel[i] = 1'b1;
        free_found   = 1'b1;
      end
    end
  end

  always_comb begin
    x_left_d    = x_left_q;
    x_right_d   = x_right_q;
    y_up_d      = y_up_q;
    y_down_d    = y_down_q;
    score_d     = score_q;
    speed_d     = speed_q;
    spawn_cnt_d = spawn_cnt_q;
    level_cnt_d = level_cnt_q;
    pass_cnt    = '0;
    score_sum   = '0;
    // The LFSR free-runs in every gamemode so spawn heights depend on how
    // long the player idled, not just on the frame count since a clear.
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (gamemode_e'(gamemode))
      GM_CLEAR: begin
        x_left_d    = '0;
        x_right_d   = '0;
        y_up_d      = '0;
        y_down_d    = '0;
        score_d     = '0;
        speed_d     = INIT_SPD_C;
        spawn_cnt_d = SPAWN_MIN_C;
        level_cnt_d = '0;
      end

      GM_RUN: begin
        for (int i = 0; i < NUM_OBS; i++) begin
          if (slot_active[i]) begin
            if (x_right_q[i] <= speed_ext) begin
              x_left_d[i]  = '0;
              x_right_d[i] = '0;
              y_up_d[i]    = '0;
              y_down_d[i]  = '0;
              if (x_right_q[i] >= PLAYER_X) begin
                pass_cnt = pass_cnt + PASS_W'(1);
              end
            end else begin
              x_right_d[i] = x_right_q[i] - speed_ext;
              x_left_d[i]  = (x_left_q[i] < speed_ext) ? 10'd0 : (x_left_q[i] - speed_ext);
              if ((x_right_q[i] >= PLAYER_X) && (x_right_d[i] < PLAYER_X)) begin
                pass_cnt = pass_cnt + PASS_W'(1);
              end
            end
          end
        end

        // The target slot was free, so the scroll loop left it alone and
        // the fresh obstacle is not moved in its spawn frame.
        if (spawn_cnt_q != 8'd0) begin
          spawn_cnt_d = spawn_cnt_q - 8'd1;
        end else if (free_found) begin
          for (int i = 0; i < NUM_OBS; i++) begin
            if (spawn_sel[i]) begin
              x_left_d[i]  = SPAWN_XL;
              x_right_d[i] = SPAWN_XR;
              y_up_d[i]    = spawn_y_up;
              y_down_d[i]  = spawn_y_down;
            end
          end
          spawn_cnt_d = SPAWN_MIN_C + {3'd0, lfsr_q[4:0]};
        end

        score_sum = {1'b0, score_q} + 17'(pass_cnt);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        if (level_cnt_q == LEVEL_LAST) begin
          level_cnt_d = '0;
          if (speed_q < MAX_SPD_C) begin
            speed_d = speed_q + 4'd1;
          end
        end else begin
          level_cnt_d = level_cnt_q + 16'd1;
        end
      end

      default: begin
        // Pause and crashed freeze the field; only the LFSR moves.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_left_q    <= '0;
      x_right_q   <= '0;
      y_up_q      <= '0;
      y_down_q    <= '0;
      score_q     <= '0;
      speed_q     <= INIT_SPD_C;
      spawn_cnt_q <= SPAWN_MIN_C;
      level_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      x_left_q    <= x_left_d;
      x_right_q   <= x_right_d;
      y_up_q      <= y_up_d;
      y_down_q    <= y_down_d;
      score_q     <= score_d;
      speed_q     <= speed_d;
      spawn_cnt_q <= spawn_cnt_d;
      level_cnt_q <= level_cnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign obstacle_x_left  = x_left_q;
  assign obstacle_x_right = x_right_q;
  assign obstacle_y_up    = y_up_q;
  assign obstacle_y_down  = y_down_q;
  assign score            = score_q;
  assign speed            = speed_q;

endmodule

// File: tb/tb_obstacle_generator.sv
// tb/tb_obstacle_generator.sv - scoreboard bench for obstacle_generator (default and fast-spawn instances)
module tb_obstacle_generator;

  localparam int SCREEN_W  = 640;
  localparam int OBS_W     = 40;
  localparam int UPPER     = 20;
  localparam int MIN_H     = 40;
  localparam int H_STEP    = 8;
  localparam int PLAYER_X  = 160;
  localparam int MAX_SPD   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] gamemode = 2'b00;

  logic [9:0][9:0] a_xl, a_xr, b_xl, b_xr;
  logic [9:0][8:0] a_yu, a_yd, b_yu, b_yd;
  logic [15:0]     a_score, b_score;
  logic [3:0]      a_speed, b_speed;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  obstacle_generator dut_a (
    .clk(clk), .rst_n(rst_n), .gamemode(gamemode),
    .obstacle_x_left(a_xl), .obstacle_x_right(a_xr),
    .obstacle_y_up(a_yu), .obstacle_y_down(a_yd),
    .score(a_score), .speed(a_speed)
  );

  obstacle_generator #(.SPAWN_MIN(1), .INIT_SPEED(1), .LEVEL_FRAMES(4096)) dut_b (
    .clk(clk), .rst_n(rst_n), .gamemode(gamemode),
    .obstacle_x_left(b_xl), .obstacle_x_right(b_xr),
    .obstacle_y_up(b_yu), .obstacle_y_down(b_yd),
    .score(b_score), .speed(b_speed)
  );

  // Reference model: plain integer state per instance (0 = default, 1 = fast spawn).
  int c_spawn_min[2]  = '{45, 1};
  int c_init_speed[2] = '{4, 1};
  int c_level_fr[2]   = '{600, 4096};

  int m_xl[2][10];
  int m_xr[2][10];
  int m_yu[2][10];
  int m_yd[2][10];
  int m_score[2];
  int m_speed[2];
  int m_spawn[2];
  int m_level[2];
  int m_lfsr[2];

  typedef struct packed {
    logic [9:0][9:0] xl;
    logic [9:0][9:0] xr;
    logic [9:0][8:0] yu;
    logic [9:0][8:0] yd;
    logic [15:0]     score;
    logic [3:0]      speed;
    logic [7:0]      spawn;
    logic [15:0]     lfsr;
  } snap_t;

  typedef struct packed {
    snap_t a;
    snap_t b;
  } pair_t;

  pair_t exp_q[$];

  function automatic int lfsr_next(int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 'hFFFF;
  endfunction

  task automatic model_clear(int k, bit reseed);
    for (int j = 0; j < 10; j++) begin
      m_xl[k][j] = 0; m_xr[k][j] = 0; m_yu[k][j] = 0; m_yd[k][j] = 0;
    end
    m_score[k] = 0;
    m_speed[k] = c_init_speed[k];
    m_spawn[k] = c_spawn_min[k];
    m_level[k] = 0;
    if (reseed) m_lfsr[k] = 'hACE1;
  endtask

  task automatic model_step(int k, logic [1:0] gm);
    int old_l;
    int free_slot;
    int passed;
    int xr;
    old_l = m_lfsr[k];
    m_lfsr[k] = lfsr_next(old_l);
    if (gm == 2'b00) begin
      model_clear(k, 1'b0);
    end else if (gm == 2'b01) begin
      free_slot = -1;
      passed = 0;
      for (int j = 9; j >= 0; j--) begin
        if (m_xl[k][j] == 0 && m_xr[k][j] == 0 && m_yu[k][j] == 0 && m_yd[k][j] == 0)
          free_slot = j;
      end
      for (int j = 0; j < 10; j++) begin
        if (j != free_slot && (m_xl[k][j] | m_xr[k][j] | m_yu[k][j] | m_yd[k][j]) != 0) begin
          xr = m_xr[k][j];
          if (xr <= m_speed[k]) begin
            m_xl[k][j] = 0; m_xr[k][j] = 0; m_yu[k][j] = 0; m_yd[k][j] = 0;
          end else begin
            m_xr[k][j] = xr - m_speed[k];
            m_xl[k][j] = (m_xl[k][j] > m_speed[k]) ? m_xl[k][j] - m_speed[k] : 0;
          end
          if (xr >= PLAYER_X && m_xr[k][j] < PLAYER_X) passed++;
        end
      end
      if (m_spawn[k] > 0) begin
        m_spawn[k]--;
      end else if (free_slot >= 0) begin
        m_xl[k][free_slot] = SCREEN_W;
        m_xr[k][free_slot] = SCREEN_W + OBS_W;
        m_yu[k][free_slot] = UPPER + (old_l & 255);
        m_yd[k][free_slot] = m_yu[k][free_slot] + MIN_H + ((old_l >> 10) & 15) * H_STEP;
        m_spawn[k] = c_spawn_min[k] + (old_l & 31);
      end
      m_score[k] = (m_score[k] + passed > 65535) ? 65535 : m_score[k] + passed;
      m_level[k]++;
      if (m_level[k] == c_level_fr[k]) begin
        m_level[k] = 0;
        if (m_speed[k] < MAX_SPD) m_speed[k]++;
      end
    end
  endtask

  function automatic snap_t model_snap(int k);
    snap_t s;
    for (int j = 0; j < 10; j++) begin
      s.xl[j] = 10'(m_xl[k][j]);
      s.xr[j] = 10'(m_xr[k][j]);
      s.yu[j] = 9'(m_yu[k][j]);
      s.yd[j] = 9'(m_yd[k][j]);
    end
    s.score = 16'(m_score[k]);
    s.speed = 4'(m_speed[k]);
    s.spawn = 8'(m_spawn[k]);
    s.lfsr  = 16'(m_lfsr[k]);
    return s;
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic compare_snap(string tag, snap_t got, snap_t exp);
    check({tag, ".x_left"},    got.xl,    exp.xl);
    check({tag, ".x_right"},   got.xr,    exp.xr);
    check({tag, ".y_up"},      got.yu,    exp.yu);
    check({tag, ".y_down"},    got.yd,    exp.yd);
    check({tag, ".score"},     got.score, exp.score);
    check({tag, ".speed"},     got.speed, exp.speed);
    check({tag, ".spawn_cnt"}, got.spawn, exp.spawn);
    check({tag, ".lfsr"},      got.lfsr,  exp.lfsr);
  endtask

  // Expected-value producer: one entry per frame; an async reset discards
  // whatever was pending and replaces it with the reset state.
  always @(posedge clk or negedge rst_n) begin
    pair_t p;
    if (!rst_n) begin
      model_clear(0, 1'b1);
      model_clear(1, 1'b1);
      exp_q.delete();
    end else begin
      model_step(0, gamemode);
      model_step(1, gamemode);
    end
    p.a = model_snap(0);
    p.b = model_snap(1);
    exp_q.push_back(p);
  end

  // Monitor: compares the registered outputs mid-cycle against the model.
  always @(negedge clk) begin
    pair_t p;
    snap_t act;
    if (exp_q.size() != 0) begin
      p = exp_q.pop_front();
      act.xl = a_xl; act.xr = a_xr; act.yu = a_yu; act.yd = a_yd;
      act.score = a_score; act.speed = a_speed;
      act.spawn = dut_a.spawn_cnt_q; act.lfsr = dut_a.lfsr_q;
      compare_snap("A", act, p.a);
      act.xl = b_xl; act.xr = b_xr; act.yu = b_yu; act.yd = b_yd;
      act.score = b_score; act.speed = b_speed;
      act.spawn = dut_b.spawn_cnt_q; act.lfsr = dut_b.lfsr_q;
      compare_snap("B", act, p.b);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    tick(3);
    check("reset_xl", a_xl, 0);
    check("reset_xr", a_xr, 0);
    check("reset_speed_a", a_speed, 4);
    check("reset_speed_b", b_speed, 1);
    check("reset_lfsr", dut_a.lfsr_q, 16'hACE1);

    rst_n = 1'b1;
    gamemode = 2'b01;
    tick(45);
    check("idle45_xl", a_xl, 0);
    check("idle45_yd", a_yd, 0);
    tick(1);
    check("spawn_xl0", a_xl[0], 640);
    check("spawn_xr0", a_xr[0], 680);
    check("spawn_yu_range", (a_yu[0] >= 20) && (a_yu[0] <= 275), 1'b1);
    check("spawn_height", ((a_yd[0] - a_yu[0]) >= 40) && ((a_yd[0] - a_yu[0]) <= 160)
                          && (((a_yd[0] - a_yu[0]) % 8) == 0), 1'b1);
    tick(1);
    check("scroll1_xl0", a_xl[0], 636);
    tick(129);
    check("pre_score_xr0", a_xr[0], 160);
    check("pre_score", a_score, 0);
    tick(1);
    check("score_xr0", a_xr[0], 156);
    check("score_one", a_score, 1);
    tick(38);
    check("last_xr0", a_xr[0], 4);
    tick(1);
    check("freed_xr0", a_xr[0], 0);
    check("freed_xl0", a_xl[0], 0);

    tick(60);
    gamemode = 2'b10;
    tick(20);
    gamemode = 2'b11;
    tick(20);
    gamemode = 2'b01;

    for (int i = 0; i < 3200; i++) begin
      r = $urandom_range(99, 0);
      gamemode = (r < 94) ? 2'b01 : ((r < 97) ? 2'b10 : 2'b11);
      tick(1);
    end
    check("speed_saturated", a_speed, 8);

    gamemode = 2'b00;
    tick(1);
    check("clear_speed", a_speed, 4);
    check("clear_score", a_score, 0);
    check("clear_xr", a_xr, 0);
    check("clear_speed_b", b_speed, 1);

    gamemode = 2'b01;
    tick(200);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_xl", a_xl, 0);
    check("async_xr", b_xr, 0);
    check("async_yu", b_yu, 0);
    check("async_score", b_score, 0);
    check("async_speed", a_speed, 4);
    check("async_lfsr", dut_b.lfsr_q, 16'hACE1);
    tick(2);
    rst_n = 1'b1;
    tick(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
